fifo2pcie: RTL and testbench

- Transmit-side counterpart of the PCIe RX capture path: pops TLP beats from a first-word-fall-through FIFO filled by the Ethernet/NetTLP decapsulation logic and drives them onto the 64-bit PCIe core TX AXI-stream.
- Enforces packet framing against the length written with the first beat.
- Discards bubble entries.
- Terminates stalled or malformed packets with the core's discontinue flag.
- Sits between the decap FIFO read port and the 7-series PCIe core s_axis_tx interface.

---
 rtl/fifo2pcie.sv | 194 +++++++++++++++++++
 tb/tb_fifo2pcie.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2pcie.sv
// fifo2pcie: drains decapsulated TLP beats from a FWFT FIFO onto the
// 64-bit PCIe core TX AXI-stream, enforcing length framing and starvation limits.
module fifo2pcie #(
  parameter int TIMEOUT    = 500,
  parameter int MIN_BUF_AV = 2
) (
  input  logic        pcie_clk,
  input  logic        pcie_rst,
  output logic        rd_en,
  input  logic [85:0] dout,
  input  logic        empty,
  input  logic [5:0]  tx_buf_av,
  input  logic        pcie_tx_tready,
  output logic        pcie_tx_tvalid,
  output logic        pcie_tx_tlast,
  output logic [7:0]  pcie_tx_tkeep,
  output logic [63:0] pcie_tx_tdata,
  output logic [3:0]  pcie_tx_tuser,
  output logic [31:0] pkt_cnt,
  output logic [15:0] err_len_cnt,
  output logic [15:0] err_timeout_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [5:0] BUF_MIN = 6'(MIN_BUF_AV);

  typedef enum logic [1:0] {IDLE, SEND, DROP, TERM} state_t;

  state_t        state, state_nx;
  logic [12:0]   bytes_q, bytes_nx;
  logic [11:0]   len_q, len_nx;
  logic [TW-1:0] tcnt_q, tcnt_nx;
  logic          tuser_q;

  logic [63:0] e_data;
  logic [7:0]  e_keep;
  logic        e_last, e_dv;
  logic [11:0] e_len;
  logic [12:0] e_bytes, sum;
  logic        load_ok;

  logic        pop, ld, ld_last, ld_user;
  logic [7:0]  ld_keep;
  logic [63:0] ld_data;
  logic        pkt_inc, elen_inc, eto_inc;

  assign e_data  = dout[63:0];
  assign e_keep  = dout[71:64];
  assign e_last  = dout[72];
  assign e_dv    = dout[73];
  assign e_len   = dout[85:74];
  assign e_bytes = (|e_keep[7:4] ? 13'd4 : 13'd0)
                 + (|e_keep[3:0] ? 13'd4 : 13'd0);
  assign sum     = bytes_q + e_bytes;
  assign load_ok = !pcie_tx_tvalid || pcie_tx_tready;

  // Pop is qualified with reset so the FIFO is never touched while held.
  assign rd_en         = pop && !pcie_rst;
  assign pcie_tx_tuser = {tuser_q, 3'b000};

  always_comb begin
    state_nx = state;
    bytes_nx = bytes_q;
    len_nx   = len_q;
    tcnt_nx  = tcnt_q;
    pop      = 1'b0;
    ld       = 1'b0;
    ld_last  = e_last;
    ld_user  = 1'b0;
    ld_keep  = e_keep;
    ld_data  = e_data;
    pkt_inc  = 1'b0;
    elen_inc = 1'b0;
    eto_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        tcnt_nx = '0;
        if (!empty && !e_dv) begin
          pop = 1'b1;
        end else if (!empty && tx_buf_av >= BUF_MIN && load_ok) begin
          pop      = 1'b1;
          ld       = 1'b1;
          pkt_inc  = 1'b1;
          len_nx   = e_len;
          bytes_nx = e_bytes;
          if (e_last) begin
            if ({1'b0, e_len} != e_bytes) begin
              ld_user  = 1'b1;
              elen_inc = 1'b1;
            end
          end else begin
            state_nx = SEND;
          end
        end
      end
      SEND: begin
        if (!empty && load_ok) begin
          pop     = 1'b1;
          tcnt_nx = '0;
          if (e_dv) begin
            ld       = 1'b1;
            bytes_nx = sum;
            if (e_last) begin
              state_nx = IDLE;
              if (sum != {1'b0, len_q}) begin
                ld_user  = 1'b1;
                elen_inc = 1'b1;
              end
            end else if (sum >= {1'b0, len_q}) begin
              // Overrun: close the packet here and discard its tail.
              ld_last  = 1'b1;
              ld_user  = 1'b1;
              elen_inc = 1'b1;
              state_nx = DROP;
            end
          end
        end else if (tcnt_q == TMAX) begin
          state_nx = TERM;
        end else if (empty) begin
          tcnt_nx = tcnt_q + 1'b1;
        end
      end
      DROP: begin
        tcnt_nx = '0;
        if (!empty) begin
          pop = 1'b1;
          if (e_last) state_nx = IDLE;
        end
      end
      TERM: begin
        tcnt_nx = '0;
        if (load_ok) begin
          ld       = 1'b1;
          ld_last  = 1'b1;
          ld_user  = 1'b1;
          ld_keep  = 8'hFF;
          ld_data  = '0;
          eto_inc  = 1'b1;
          state_nx = DROP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state   <= IDLE;
      bytes_q <= '0;
      len_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state   <= state_nx;
      bytes_q <= bytes_nx;
      len_q   <= len_nx;
      tcnt_q  <= tcnt_nx;
    end
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      pcie_tx_tvalid <= 1'b0;
      pcie_tx_tlast  <= 1'b0;
      pcie_tx_tkeep  <= '0;
      pcie_tx_tdata  <= '0;
      tuser_q        <= 1'b0;
    end else if (load_ok) begin
      pcie_tx_tvalid <= ld;
      if (ld) begin
        pcie_tx_tlast <= ld_last;
        pcie_tx_tkeep <= ld_keep;
        pcie_tx_tdata <= ld_data;
        tuser_q       <= ld_user;
      end
    end
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      pkt_cnt         <= '0;
      err_len_cnt     <= '0;
      err_timeout_cnt <= '0;
    end else begin
      if (pkt_inc)
        pkt_cnt <= pkt_cnt + 32'd1;
      if (elen_inc && err_len_cnt != 16'hFFFF)
        err_len_cnt <= err_len_cnt + 16'd1;
      if (eto_inc && err_timeout_cnt != 16'hFFFF)
        err_timeout_cnt <= err_timeout_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo2pcie.sv
// tb_fifo2pcie: queue-backed FWFT FIFO feeding fifo2pcie, with a packet-level
// reference model predicting the beats accepted on the TX stream.
module tb_fifo2pcie;

  localparam int TIMEOUT = 500;

  logic        pcie_clk = 1'b0;
  logic        pcie_rst = 1'b1;
  logic        rd_en;
  logic [85:0] dout = '0;
  logic        empty = 1'b1;
  logic [5:0]  tx_buf_av = '0;
  logic        pcie_tx_tready = 1'b0;
  logic        pcie_tx_tvalid;
  logic        pcie_tx_tlast;
  logic [7:0]  pcie_tx_tkeep;
  logic [63:0] pcie_tx_tdata;
  logic [3:0]  pcie_tx_tuser;
  logic [31:0] pkt_cnt;
  logic [15:0] err_len_cnt;
  logic [15:0] err_timeout_cnt;

  fifo2pcie #(.TIMEOUT(TIMEOUT), .MIN_BUF_AV(2)) dut (
    .pcie_clk        (pcie_clk),
    .pcie_rst        (pcie_rst),
    .rd_en           (rd_en),
    .dout            (dout),
    .empty           (empty),
    .tx_buf_av       (tx_buf_av),
    .pcie_tx_tready  (pcie_tx_tready),
    .pcie_tx_tvalid  (pcie_tx_tvalid),
    .pcie_tx_tlast   (pcie_tx_tlast),
    .pcie_tx_tkeep   (pcie_tx_tkeep),
    .pcie_tx_tdata   (pcie_tx_tdata),
    .pcie_tx_tuser   (pcie_tx_tuser),
    .pkt_cnt         (pkt_cnt),
    .err_len_cnt     (err_len_cnt),
    .err_timeout_cnt (err_timeout_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  int vec = 0, errs = 0;
  logic [85:0] fq[$], stim[$], tmp;
  logic [76:0] obs[$], exp_q[$], held_beat, hb;
  int exp_pkt = 0, exp_elen = 0, exp_eto = 0;
  int pops = 0, stab_err = 0, rde_err = 0;
  int rdy_mode = 1;
  bit bav_rand = 0;
  logic [5:0] bav_val = 6'd8;
  bit rd_l = 0, held = 0;
  wire [76:0] beat = {pcie_tx_tuser, pcie_tx_tlast, pcie_tx_tkeep, pcie_tx_tdata};

  // FIFO model and input drivers, updated just after each rising edge.
  always @(posedge pcie_clk) begin
    #1;
    if (rd_l && fq.size() > 0) begin
      tmp = fq.pop_front();
      pops++;
    end
    rd_l = 0;
    empty = (fq.size() == 0);
    dout = empty ? '0 : fq[0];
    pcie_tx_tready = (rdy_mode == 1) ||
                     (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    tx_buf_av = bav_rand ? 6'($urandom_range(0, 63)) : bav_val;
  end

  always @(negedge pcie_clk) begin
    rd_l = rd_en;
    if (pcie_rst) held = 0;
    else begin
      if (rd_en && empty) rde_err++;
      if (held && (!pcie_tx_tvalid || beat !== held_beat)) stab_err++;
      if (pcie_tx_tvalid && pcie_tx_tready) obs.push_back(beat);
      held = pcie_tx_tvalid && !pcie_tx_tready;
      held_beat = beat;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [85:0] ent(logic [11:0] len, bit dv, bit last,
                                      logic [7:0] keep, logic [63:0] d);
    return {len, dv, last, keep, d};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic gen_pkt(input int len_dw, input int act_dw, input int bub);
    int nb = (act_dw + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      if (int'($urandom_range(0, 99)) < bub)
        stim.push_back(ent(12'($urandom), 0, 0, 8'hFF, rnd64()));
      stim.push_back(ent(k == 0 ? 12'(len_dw * 4) : 12'($urandom), 1,
                         k == nb - 1,
                         (k == nb - 1 && act_dw % 2 == 1) ? 8'h0F : 8'hFF,
                         rnd64()));
    end
  endtask

  // Packet-level prediction: walks the entry stream, ignoring timing.
  task automatic load_stim();
    int st = 0, by = 0, ln = 0, kb;
    bit dv, last, u;
    foreach (stim[i]) begin
      dv   = stim[i][73];
      last = stim[i][72];
      kb   = 4 * ((stim[i][71:64] == 8'hFF) ? 2 : 1);
      if (st == 0 && dv) begin
        exp_pkt++;
        ln = int'(stim[i][85:74]);
        by = kb;
        u  = last && (by != ln);
        if (u) exp_elen++;
        exp_q.push_back({u, 3'b0, last, stim[i][71:0]});
        st = last ? 0 : 1;
      end else if (st == 1 && dv) begin
        by += kb;
        if (last) begin
          u = (by != ln);
          if (u) exp_elen++;
          exp_q.push_back({u, 3'b0, 1'b1, stim[i][71:0]});
          st = 0;
        end else if (by >= ln) begin
          exp_elen++;
          exp_q.push_back({4'h8, 1'b1, stim[i][71:0]});
          st = 2;
        end else begin
          exp_q.push_back({4'h0, 1'b0, stim[i][71:0]});
        end
      end else if (st == 2 && last) begin
        st = 0;
      end
    end
    foreach (stim[i]) fq.push_back(stim[i]);
    stim.delete();
  endtask

  task automatic drain(input string nm, input int maxc);
    bit ok = 0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge pcie_clk);
      ok = (fq.size() == 0 && empty && !pcie_tx_tvalid);
    end
    repeat (2) @(negedge pcie_clk);
    if (!ok) begin
      vec++; errs++;
      $display("FAIL %s drain: bus still busy after %0d cycles", nm, maxc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pcie_clk);
    fq.push_back(ent(12'd12, 0, 0, 8'hFF, 64'h0));
    repeat (3) @(negedge pcie_clk);
    vec++;
    if (rd_en !== 1'b0) begin
      errs++; $display("FAIL reset_rd_en got %b exp 0", rd_en);
    end
    vec++;
    if ({pcie_tx_tvalid, pcie_tx_tlast, pcie_tx_tkeep, pcie_tx_tdata,
         pcie_tx_tuser} !== '0) begin
      errs++; $display("FAIL reset_bus got %h exp 0", beat);
    end
    vec++;
    if ({pkt_cnt, err_len_cnt, err_timeout_cnt} !== '0) begin
      errs++; $display("FAIL reset_cnt got %h/%h/%h exp 0", pkt_cnt,
                       err_len_cnt, err_timeout_cnt);
    end
    pcie_rst = 0;
    drain("reset", 50);
    vec++;
    if (obs.size() != 0 || pops != 1) begin
      errs++; $display("FAIL reset_bubble got beats=%0d pops=%0d exp 0/1",
                       obs.size(), pops);
    end
  endtask

  task automatic test_mrd();
    logic [63:0] d;
    obs.delete(); exp_q.delete();
    gen_pkt(3, 3, 0);
    load_stim();
    for (int n = 0; n < 20 && rd_en !== 1'b1; n++) @(negedge pcie_clk);
    d = dout[63:0];
    @(negedge pcie_clk);
    vec++;
    if (pcie_tx_tvalid !== 1'b1 || pcie_tx_tdata !== d) begin
      errs++; $display("FAIL mrd_latency got v=%b d=%h exp v=1 d=%h",
                       pcie_tx_tvalid, pcie_tx_tdata, d);
    end
    drain("mrd", 100);
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL mrd_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (obs.size() != 2 || pkt_cnt !== 32'(exp_pkt)) begin
      errs++; $display("FAIL mrd_count got beats=%0d pkt=%0d exp 2/%0d",
                       obs.size(), pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_mwr_stall();
    int p0;
    obs.delete(); exp_q.delete();
    gen_pkt(7, 7, 0);
    load_stim();
    for (int n = 0; n < 50 && obs.size() < 1; n++) @(negedge pcie_clk);
    rdy_mode = 0;
    @(negedge pcie_clk);
    p0 = pops;
    hb = beat;
    vec++;
    if (pcie_tx_tvalid !== 1'b1) begin
      errs++; $display("FAIL stall_valid got %b exp 1", pcie_tx_tvalid);
    end
    repeat (3) begin
      @(negedge pcie_clk);
      vec++;
      if (beat !== hb || pops != p0) begin
        errs++; $display("FAIL stall_hold got %h pops=%0d exp %h pops=%0d",
                         beat, pops, hb, p0);
      end
    end
    rdy_mode = 1;
    drain("mwr", 100);
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL mwr_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (obs.size() != 4 || err_len_cnt !== 16'(exp_elen)) begin
      errs++; $display("FAIL mwr_count got beats=%0d elen=%0d exp 4/%0d",
                       obs.size(), err_len_cnt, exp_elen);
    end
  endtask

  task automatic test_bubbles();
    int p0 = pops, ne;
    obs.delete(); exp_q.delete();
    stim.push_back(ent(12'd40, 0, 0, 8'hFF, rnd64()));
    stim.push_back(ent(12'd12, 0, 0, 8'h0F, rnd64()));
    gen_pkt(7, 7, 60);
    stim.push_back(ent(12'd0, 0, 0, 8'hFF, rnd64()));
    ne = stim.size();
    load_stim();
    drain("bubbles", 200);
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL bub_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (obs.size() != 4 || pops - p0 != ne) begin
      errs++; $display("FAIL bub_count got beats=%0d pops=%0d exp 4/%0d",
                       obs.size(), pops - p0, ne);
    end
  endtask

  task automatic test_len_err();
    obs.delete(); exp_q.delete();
    gen_pkt(7, 4, 0);
    gen_pkt(3, 6, 0);
    gen_pkt(4, 4, 0);
    load_stim();
    drain("len_err", 200);
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL len_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (obs.size() != exp_q.size() || err_len_cnt !== 16'(exp_elen) ||
        pkt_cnt !== 32'(exp_pkt)) begin
      errs++; $display("FAIL len_count got beats=%0d elen=%0d pkt=%0d exp %0d/%0d/%0d",
                       obs.size(), err_len_cnt, pkt_cnt, exp_q.size(),
                       exp_elen, exp_pkt);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] d = rnd64();
    int n = 0;
    obs.delete(); exp_q.delete();
    fq.push_back(ent(12'd28, 1, 0, 8'hFF, d));
    exp_q.push_back({4'h0, 1'b0, 8'hFF, d});
    exp_q.push_back({4'h8, 1'b1, 8'hFF, 64'h0});
    exp_pkt++;
    exp_eto++;
    for (int k = 0; k < 50 && obs.size() < 1; k++) @(negedge pcie_clk);
    while (n < 800 && obs.size() < 2) begin
      @(negedge pcie_clk);
      n++;
    end
    vec++;
    if (n < TIMEOUT || n > TIMEOUT + 10) begin
      errs++; $display("FAIL timeout_delay got %0d cycles exp %0d..%0d",
                       n, TIMEOUT, TIMEOUT + 10);
    end
    fq.push_back(ent(12'd99, 1, 0, 8'hFF, rnd64()));
    fq.push_back(ent(12'd99, 1, 1, 8'h0F, rnd64()));
    gen_pkt(3, 3, 0);
    load_stim();
    drain("timeout", 200);
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL to_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (obs.size() != 4 || err_timeout_cnt !== 16'(exp_eto) ||
        err_len_cnt !== 16'(exp_elen)) begin
      errs++; $display("FAIL to_count got beats=%0d eto=%0d elen=%0d exp 4/%0d/%0d",
                       obs.size(), err_timeout_cnt, err_len_cnt, exp_eto,
                       exp_elen);
    end
  endtask

  task automatic test_buf_av();
    int p0;
    obs.delete(); exp_q.delete();
    bav_val = 6'd1;
    @(negedge pcie_clk);
    p0 = pops;
    gen_pkt(7, 7, 0);
    load_stim();
    repeat (20) @(negedge pcie_clk);
    vec++;
    if (pops != p0 || obs.size() != 0) begin
      errs++; $display("FAIL bav_hold got pops=%0d beats=%0d exp 0/0",
                       pops - p0, obs.size());
    end
    bav_val = 6'd2;
    for (int n = 0; n < 50 && obs.size() < 1; n++) @(negedge pcie_clk);
    bav_val = 6'd0;
    drain("buf_av", 100);
    bav_val = 6'd8;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL bav_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int ldw, sel, act;
    obs.delete(); exp_q.delete();
    rdy_mode = 2;
    bav_rand = 1;
    for (int p = 0; p < 40; p++) begin
      ldw = 3 + int'($urandom_range(0, 12));
      sel = int'($urandom_range(0, 3));
      act = (sel == 0) ? int'($urandom_range(1, ldw - 1)) :
            (sel == 1) ? ldw + int'($urandom_range(1, 6)) : ldw;
      gen_pkt(ldw, act, 20);
    end
    load_stim();
    drain("random", 20000);
    rdy_mode = 1;
    bav_rand = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL rnd_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (obs.size() != exp_q.size() || pkt_cnt !== 32'(exp_pkt) ||
        err_len_cnt !== 16'(exp_elen)) begin
      errs++; $display("FAIL rnd_count got beats=%0d pkt=%0d elen=%0d exp %0d/%0d/%0d",
                       obs.size(), pkt_cnt, err_len_cnt, exp_q.size(),
                       exp_pkt, exp_elen);
    end
    vec++;
    if (stab_err != 0 || rde_err != 0) begin
      errs++; $display("FAIL rnd_protocol got unstable=%0d rd_empty=%0d exp 0/0",
                       stab_err, rde_err);
    end
  endtask

  task automatic test_reset_mid();
    obs.delete(); exp_q.delete();
    gen_pkt(15, 15, 0);
    load_stim();
    for (int n = 0; n < 50 && obs.size() < 2; n++) @(negedge pcie_clk);
    pcie_rst = 1;
    #1;
    vec++;
    if ({rd_en, pcie_tx_tvalid, pcie_tx_tlast, pcie_tx_tkeep, pcie_tx_tdata,
         pcie_tx_tuser} !== '0) begin
      errs++; $display("FAIL rstmid_bus got rd=%b %h exp 0", rd_en, beat);
    end
    vec++;
    if ({pkt_cnt, err_len_cnt, err_timeout_cnt} !== '0) begin
      errs++; $display("FAIL rstmid_cnt got %h/%h/%h exp 0", pkt_cnt,
                       err_len_cnt, err_timeout_cnt);
    end
    fq.delete();
    repeat (3) @(negedge pcie_clk);
    pcie_rst = 0;
    exp_pkt = 0; exp_elen = 0; exp_eto = 0;
    obs.delete(); exp_q.delete();
    gen_pkt(3, 3, 0);
    load_stim();
    drain("reset_mid", 100);
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (i >= obs.size() || obs[i] !== exp_q[i]) begin
        errs++; $display("FAIL rstmid_beat%0d got %h exp %h", i,
                         i < obs.size() ? obs[i] : 'x, exp_q[i]);
      end
    end
    vec++;
    if (pkt_cnt !== 32'(exp_pkt)) begin
      errs++; $display("FAIL rstmid_pkt got %0d exp %0d", pkt_cnt, exp_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_mrd();
    test_mwr_stall();
    test_bubbles();
    test_len_err();
    test_timeout();
    test_buf_av();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
